// File: rtl/rob_alloc_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rob_alloc_ctrl_pkg                                                       |
// | Shared sizes and record types for the ROB allocation controller.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rob_alloc_ctrl_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;

  typedef logic [ROB_IDX_W-1:0] robIdx_t;

  // Allocation result, laid out so robNum1/2 feed the dispatch record directly
  typedef struct packed {
    logic    grant1;
    logic    grant2;
    robIdx_t robNum1;
    robIdx_t robNum2;
    logic    stall;
  } robAllocStruct;

  typedef struct packed {
    logic    valid1;
    logic    valid2;
    robIdx_t idx1;
    robIdx_t idx2;
  } retireOfferStruct;

endpackage
`default_nettype wire

// File: rtl/rob_alloc_ctrl_done_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rob_done_tracker                                                         |
// | Per-entry valid/done bits with allocate, complete and retire updates.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rob_done_tracker #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  set_en1,
  input  logic                  set_en2,
  input  logic [IDX_W-1:0]      set_idx1,
  input  logic [IDX_W-1:0]      set_idx2,
  input  logic [2:0]            cmpl_valid,
  input  logic [2:0][IDX_W-1:0] cmpl_idx,
  input  logic                  clr_en1,
  input  logic                  clr_en2,
  input  logic [IDX_W-1:0]      rd_idx1,
  input  logic [IDX_W-1:0]      rd_idx2,
  output logic                  rdy1,
  output logic                  rdy2
);

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_done;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic r_v;
      logic r_d;
      logic w_hit;
      logic w_clr;
      logic w_set;

      always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (cmpl_valid[k] && (cmpl_idx[k] == IDX_W'(i))) w_hit = 1'b1;
        end
      end

      assign w_clr = (clr_en1 && (rd_idx1 == IDX_W'(i))) ||
                     (clr_en2 && (rd_idx2 == IDX_W'(i)));
      assign w_set = (set_en1 && (set_idx1 == IDX_W'(i))) ||
                     (set_en2 && (set_idx2 == IDX_W'(i)));

      // Retire and allocate never target the same entry; completions only land on live entries
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_v <= 1'b0;
          r_d <= 1'b0;
        end else if (flush || w_clr) begin
          r_v <= 1'b0;
          r_d <= 1'b0;
        end else if (w_set) begin
          r_v <= 1'b1;
          r_d <= 1'b0;
        end else if (r_v && w_hit) begin
          r_d <= 1'b1;
        end
      end

      assign w_valid[i] = r_v;
      assign w_done[i]  = r_d;
    end
  endgenerate

  assign rdy1 = w_valid[rd_idx1] & w_done[rd_idx1];
  assign rdy2 = w_valid[rd_idx2] & w_done[rd_idx2];

endmodule
`default_nettype wire

// File: rtl/rob_alloc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rob_alloc_ctrl                                                           |
// | ROB head/tail/count control: dispatch grant, completion, retire offer.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rob_alloc_ctrl
  import rob_alloc_ctrl_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_req1,
  input  logic             disp_req2,
  output logic             disp_grant1,
  output logic             disp_grant2,
  output logic [IDX_W-1:0] rob_num1,
  output logic [IDX_W-1:0] rob_num2,
  output logic             disp_stall,
  input  logic             cmpl_valid1,
  input  logic             cmpl_valid2,
  input  logic             cmpl_valid3,
  input  logic [IDX_W-1:0] cmpl_rob1,
  input  logic [IDX_W-1:0] cmpl_rob2,
  input  logic [IDX_W-1:0] cmpl_rob3,
  input  logic             ret_ready,
  output logic             ret_valid1,
  output logic             ret_valid2,
  output logic [IDX_W-1:0] ret_idx1,
  output logic [IDX_W-1:0] ret_idx2,
  output logic [IDX_W:0]   rob_count,
  output logic             rob_full,
  output logic             rob_empty
);

  localparam logic [IDX_W:0] C_DEPTH = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  logic [1:0]       w_ndisp;
  logic [1:0]       w_ngrant;
  logic [1:0]       w_nret;
  logic [IDX_W:0]   w_free;
  logic             w_illegal;
  logic             w_fits;
  logic [IDX_W-1:0] w_head_p1;
  logic             w_rdy1;
  logic             w_rdy2;
  logic             w_ret1;
  logic             w_ret2;
  logic [IDX_W+1:0] w_count_sum;
  robAllocStruct    w_alloc;
  retireOfferStruct w_offer;

  assign w_ndisp   = {1'b0, disp_req1} + {1'b0, disp_req2};
  assign w_free    = C_DEPTH - r_count;
  assign w_illegal = disp_req2 & ~disp_req1;
  assign w_fits    = w_free >= {{(IDX_W-1){1'b0}}, w_ndisp};
  assign w_head_p1 = r_head + IDX_W'(1);

  // Grant is all-or-nothing against registered occupancy; retires this cycle give no credit
  always_comb begin
    w_alloc         = '0;
    w_alloc.robNum1 = r_tail;
    w_alloc.robNum2 = r_tail + IDX_W'(1);
    if (!flush && !w_illegal && w_fits) begin
      w_alloc.grant1 = disp_req1;
      w_alloc.grant2 = disp_req2;
    end
    w_alloc.stall = !flush && (disp_req1 || disp_req2) &&
                    !(w_alloc.grant1 || w_alloc.grant2);
  end

  always_comb begin
    w_offer        = '0;
    w_offer.idx1   = r_head;
    w_offer.idx2   = w_head_p1;
    w_offer.valid1 = !flush && w_rdy1;
    w_offer.valid2 = !flush && w_rdy1 && w_rdy2;
  end

  assign w_ret1      = ret_ready & w_offer.valid1;
  assign w_ret2      = ret_ready & w_offer.valid2;
  assign w_ngrant    = {1'b0, w_alloc.grant1} + {1'b0, w_alloc.grant2};
  assign w_nret      = {1'b0, w_ret1} + {1'b0, w_ret2};
  assign w_count_sum = {1'b0, r_count} + (IDX_W+2)'(w_ngrant);

  rob_done_tracker #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .set_en1    (w_alloc.grant1),
    .set_en2    (w_alloc.grant2),
    .set_idx1   (w_alloc.robNum1),
    .set_idx2   (w_alloc.robNum2),
    .cmpl_valid ({cmpl_valid3, cmpl_valid2, cmpl_valid1}),
    .cmpl_idx   ({cmpl_rob3, cmpl_rob2, cmpl_rob1}),
    .clr_en1    (w_ret1),
    .clr_en2    (w_ret2),
    .rd_idx1    (r_head),
    .rd_idx2    (w_head_p1),
    .rdy1       (w_rdy1),
    .rdy2       (w_rdy2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + IDX_W'(w_nret);
      r_tail  <= r_tail + IDX_W'(w_ngrant);
      r_count <= r_count + (IDX_W+1)'(w_ngrant) - (IDX_W+1)'(w_nret);
    end
  end

  a_req2_needs_req1: assert property (@(posedge clk) disable iff (!reset)
    !(disp_req2 && !disp_req1))
    else $error("rob_alloc_ctrl: disp_req2 without disp_req1");

  a_count_bounds: assert property (@(posedge clk) disable iff (!reset)
    flush || ((w_count_sum >= (IDX_W+2)'(w_nret)) &&
              (w_count_sum - (IDX_W+2)'(w_nret) <= (IDX_W+2)'(DEPTH))))
    else $error("rob_alloc_ctrl: occupancy out of range");

  assign disp_grant1 = w_alloc.grant1;
  assign disp_grant2 = w_alloc.grant2;
  assign rob_num1    = w_alloc.robNum1;
  assign rob_num2    = w_alloc.robNum2;
  assign disp_stall  = w_alloc.stall;
  assign ret_valid1  = w_offer.valid1;
  assign ret_valid2  = w_offer.valid2;
  assign ret_idx1    = w_offer.idx1;
  assign ret_idx2    = w_offer.idx2;
  assign rob_count   = r_count;
  assign rob_full    = r_count == C_DEPTH;
  assign rob_empty   = r_count == '0;

endmodule
`default_nettype wire

// File: tb/tb_rob_alloc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rob_alloc_ctrl                                                        |
// | Directed vector table plus multi-cycle sequences for rob_alloc_ctrl.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rob_alloc_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       disp_req1 = 1'b0, disp_req2 = 1'b0;
  logic       disp_grant1, disp_grant2, disp_stall;
  logic [3:0] rob_num1, rob_num2;
  logic       cmpl_valid1 = 1'b0, cmpl_valid2 = 1'b0, cmpl_valid3 = 1'b0;
  logic [3:0] cmpl_rob1 = '0, cmpl_rob2 = '0, cmpl_rob3 = '0;
  logic       ret_ready = 1'b0;
  logic       ret_valid1, ret_valid2;
  logic [3:0] ret_idx1, ret_idx2;
  logic [4:0] rob_count;
  logic       rob_full, rob_empty;

  int checks = 0;
  int errors = 0;

  rob_alloc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .disp_req1   (disp_req1),
    .disp_req2   (disp_req2),
    .disp_grant1 (disp_grant1),
    .disp_grant2 (disp_grant2),
    .rob_num1    (rob_num1),
    .rob_num2    (rob_num2),
    .disp_stall  (disp_stall),
    .cmpl_valid1 (cmpl_valid1),
    .cmpl_valid2 (cmpl_valid2),
    .cmpl_valid3 (cmpl_valid3),
    .cmpl_rob1   (cmpl_rob1),
    .cmpl_rob2   (cmpl_rob2),
    .cmpl_rob3   (cmpl_rob3),
    .ret_ready   (ret_ready),
    .ret_valid1  (ret_valid1),
    .ret_valid2  (ret_valid2),
    .ret_idx1    (ret_idx1),
    .ret_idx2    (ret_idx2),
    .rob_count   (rob_count),
    .rob_full    (rob_full),
    .rob_empty   (rob_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl, r1, r2;
    logic [2:0] cv;
    logic [3:0] c1, c2, c3;
    logic       rr;
    logic       g1, g2;
    logic [3:0] n1;
    logic       st, v1, v2;
    logic [3:0] ri1;
    logic [4:0] cnt;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic fl, logic r1, logic r2, logic [2:0] cv,
                              logic [3:0] c1, logic [3:0] c2, logic [3:0] c3,
                              logic rr, logic g1, logic g2, logic [3:0] n1,
                              logic st, logic v1, logic v2, logic [3:0] ri1,
                              logic [4:0] cnt);
    vec_t v;
    v.fl = fl; v.r1 = r1; v.r2 = r2; v.cv = cv; v.c1 = c1; v.c2 = c2; v.c3 = c3;
    v.rr = rr; v.g1 = g1; v.g2 = g2; v.n1 = n1; v.st = st; v.v1 = v1; v.v2 = v2;
    v.ri1 = ri1; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and settle before sampling
  task automatic cyc(input logic fl, input logic r1, input logic r2, input logic [2:0] cv,
                     input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                     input logic rr);
    @(negedge clk);
    flush = fl; disp_req1 = r1; disp_req2 = r2;
    cmpl_valid1 = cv[0]; cmpl_valid2 = cv[1]; cmpl_valid3 = cv[2];
    cmpl_rob1 = c1; cmpl_rob2 = c2; cmpl_rob3 = c3;
    ret_ready = rr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] e_n2, e_ri2;
    logic [31:0] act, exp;

    // dispatch / out-of-order completion / retire pairs
    tbl[0]  = mk(0,1,1,3'b000, 0,0,0, 0, 1,1, 0, 0,0,0, 0, 0);
    tbl[1]  = mk(0,1,1,3'b000, 0,0,0, 0, 1,1, 2, 0,0,0, 0, 2);
    tbl[2]  = mk(0,0,0,3'b001, 3,0,0, 0, 0,0, 4, 0,0,0, 0, 4);
    tbl[3]  = mk(0,0,0,3'b001, 2,0,0, 0, 0,0, 4, 0,0,0, 0, 4);
    tbl[4]  = mk(0,0,0,3'b001, 1,0,0, 0, 0,0, 4, 0,0,0, 0, 4);
    tbl[5]  = mk(0,0,0,3'b001, 0,0,0, 0, 0,0, 4, 0,0,0, 0, 4);
    tbl[6]  = mk(0,0,0,3'b000, 0,0,0, 1, 0,0, 4, 0,1,1, 0, 4);
    tbl[7]  = mk(0,0,0,3'b000, 0,0,0, 1, 0,0, 4, 0,1,1, 2, 2);
    tbl[8]  = mk(0,0,0,3'b000, 0,0,0, 0, 0,0, 4, 0,0,0, 4, 0);
    // duplicate completions, completion to a free entry, partial offers
    tbl[9]  = mk(0,1,0,3'b000, 0,0,0, 0, 1,0, 4, 0,0,0, 4, 0);
    tbl[10] = mk(0,0,0,3'b111, 4,4,7, 0, 0,0, 5, 0,0,0, 4, 1);
    tbl[11] = mk(0,1,1,3'b000, 0,0,0, 0, 1,1, 5, 0,1,0, 4, 1);
    tbl[12] = mk(0,0,0,3'b001, 6,0,0, 1, 0,0, 7, 0,1,0, 4, 3);
    tbl[13] = mk(0,0,0,3'b000, 0,0,0, 1, 0,0, 7, 0,0,0, 5, 2);
    tbl[14] = mk(0,0,0,3'b001, 5,0,0, 1, 0,0, 7, 0,0,0, 5, 2);
    tbl[15] = mk(0,1,1,3'b000, 0,0,0, 1, 1,1, 7, 0,1,1, 5, 2);
    tbl[16] = mk(0,0,0,3'b000, 0,0,0, 0, 0,0, 9, 0,0,0, 7, 2);
    // build to 9 entries, then flush
    tbl[17] = mk(0,1,1,3'b000, 0,0,0, 0, 1,1, 9, 0,0,0, 7, 2);
    tbl[18] = mk(0,1,1,3'b000, 0,0,0, 0, 1,1,11, 0,0,0, 7, 4);
    tbl[19] = mk(0,1,1,3'b000, 0,0,0, 0, 1,1,13, 0,0,0, 7, 6);
    tbl[20] = mk(0,1,0,3'b001, 7,0,0, 0, 1,0,15, 0,0,0, 7, 8);
    tbl[21] = mk(1,1,1,3'b001, 8,0,0, 1, 0,0, 0, 0,0,0, 7, 9);
    tbl[22] = mk(0,0,0,3'b000, 0,0,0, 0, 0,0, 0, 0,0,0, 0, 0);
    tbl[23] = mk(0,0,0,3'b001, 0,0,0, 1, 0,0, 0, 0,0,0, 0, 0);
    tbl[24] = mk(0,0,0,3'b000, 0,0,0, 0, 0,0, 0, 0,0,0, 0, 0);

    #1;
    chk("reset_count", 32'(rob_count), 32'd0);
    chk("reset_empty_full_num2", {29'd0, rob_empty, rob_full, ret_valid1}, 32'b100);
    chk("reset_num2", 32'(rob_num2), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].fl, tbl[i].r1, tbl[i].r2, tbl[i].cv, tbl[i].c1, tbl[i].c2, tbl[i].c3, tbl[i].rr);
      e_n2  = tbl[i].n1 + 4'd1;
      e_ri2 = tbl[i].ri1 + 4'd1;
      act = {disp_grant1, disp_grant2, rob_num1, rob_num2, disp_stall, ret_valid1,
             ret_valid2, ret_idx1, ret_idx2, rob_count, rob_full, rob_empty};
      exp = {tbl[i].g1, tbl[i].g2, tbl[i].n1, e_n2, tbl[i].st, tbl[i].v1, tbl[i].v2,
             tbl[i].ri1, e_ri2, tbl[i].cnt, tbl[i].cnt == 5'd16, tbl[i].cnt == 5'd0};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec%0d: got g=%b%b num=%0d,%0d st=%b rv=%b%b ridx=%0d,%0d cnt=%0d f=%b e=%b exp g=%b%b num=%0d,%0d st=%b rv=%b%b ridx=%0d,%0d cnt=%0d",
                 i, disp_grant1, disp_grant2, rob_num1, rob_num2, disp_stall, ret_valid1,
                 ret_valid2, ret_idx1, ret_idx2, rob_count, rob_full, rob_empty,
                 tbl[i].g1, tbl[i].g2, tbl[i].n1, e_n2, tbl[i].st, tbl[i].v1, tbl[i].v2,
                 tbl[i].ri1, e_ri2, tbl[i].cnt);
      end
    end

    // asynchronous reset mid-run with 5 occupied entries
    cyc(0,1,1,3'b000,0,0,0,0);
    cyc(0,1,1,3'b000,0,0,0,0);
    cyc(0,1,0,3'b000,0,0,0,0);
    cyc(0,0,0,3'b000,0,0,0,0);
    chk("pre_reset_count", 32'(rob_count), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_count", 32'(rob_count), 32'd0);
    chk("async_reset_flags", {30'd0, rob_empty, ret_valid1}, 32'b10);
    @(negedge clk);
    reset = 1'b1;
    cyc(0,1,1,3'b000,0,0,0,0);
    chk("post_reset_grant", {24'd0, disp_grant1, disp_grant2, rob_num1, rob_num2}, {24'd0, 2'b11, 4'd0, 4'd1});

    // fill to 16, then stall; same-cycle retire gives no credit
    for (int i = 0; i < 7; i++) cyc(0,1,1,3'b000,0,0,0,0);
    cyc(0,0,0,3'b000,0,0,0,0);
    chk("fill_count", 32'(rob_count), 32'd16);
    chk("fill_full", {31'd0, rob_full}, 32'd1);
    cyc(0,1,0,3'b000,0,0,0,0);
    chk("full_single_stall", {30'd0, disp_grant1, disp_stall}, 32'b01);
    cyc(0,0,0,3'b001,0,0,0,0);
    cyc(0,1,1,3'b000,0,0,0,1);
    chk("retire_no_credit", {26'd0, disp_grant1, disp_grant2, disp_stall, ret_valid1, ret_idx1 == 4'd0, ret_valid2},
        {26'd0, 6'b001110});
    cyc(0,1,1,3'b000,0,0,0,0);
    chk("cnt15_dual_stall", {25'd0, disp_grant1, disp_grant2, disp_stall, rob_count}, {25'd0, 3'b001, 5'd15});
    cyc(0,1,0,3'b000,0,0,0,0);
    chk("cnt15_single_grant", {27'd0, disp_grant1, disp_stall, rob_num1}, {27'd0, 2'b10, 4'd0});
    cyc(0,0,0,3'b000,0,0,0,0);
    chk("refill_full", {26'd0, rob_full, rob_count}, {26'd0, 1'b1, 5'd16});

    // wrap: walk head and tail to 14, then dispatch/retire across 15 -> 0
    do_reset();
    for (int i = 0; i < 7; i++)
      cyc(0,1,1,(i > 0) ? 3'b011 : 3'b000, 4'(2*i-2), 4'(2*i-1), 0, 0);
    cyc(0,0,0,3'b011,12,13,0,0);
    for (int i = 0; i < 7; i++) cyc(0,0,0,3'b000,0,0,0,1);
    cyc(0,1,1,3'b000,0,0,0,0);
    chk("wrap_pre", {19'd0, ret_idx1, rob_count, rob_num1, rob_num2}, {19'd0, 4'd14, 5'd0, 4'd14, 4'd15});
    cyc(0,1,1,3'b000,0,0,0,0);
    chk("wrap_num", {22'd0, disp_grant1, disp_grant2, rob_num1, rob_num2}, {22'd0, 2'b11, 4'd0, 4'd1});
    cyc(0,0,0,3'b011,14,15,0,0);
    cyc(0,1,1,3'b000,0,0,0,1);
    chk("wrap_ret_disp", {12'd0, ret_valid1, ret_valid2, ret_idx1, ret_idx2, disp_grant1, disp_grant2, rob_num1, rob_num2},
        {12'd0, 2'b11, 4'd14, 4'd15, 2'b11, 4'd2, 4'd3});
    cyc(0,0,0,3'b000,0,0,0,0);
    chk("wrap_post", {19'd0, ret_idx1, rob_num1, rob_count}, {19'd0, 4'd0, 4'd4, 5'd4});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
- Pointer and occupancy controller for the 16-entry reorder buffer.
- Hands out ROB indices to dispatch (up to 2 per cycle, in order) and stalls dispatch when the buffer lacks space.
- Records completion per entry from the 3 complete ports.
- Schedules in-order retirement of up to 2 completed entries per cycle from the head to the retire stage.

Parameters:
- DEPTH, 16, number of ROB entries; must be a power of 2.
- IDX_W, 4, ROB index width, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush; empties the ROB
- disp_req1  in  1  dispatch slot 1 wants an entry
- disp_req2  in  1  dispatch slot 2 wants an entry; only legal with disp_req1
- disp_grant1  out  1  slot 1 granted this cycle
- disp_grant2  out  1  slot 2 granted this cycle
- rob_num1  out  IDX_W  index for slot 1 (equals tail)
- rob_num2  out  IDX_W  index for slot 2 (tail+1 mod DEPTH)
- disp_stall  out  1  request present but not granted
- cmpl_valid1..3  in  1 each  complete port k reports done
- cmpl_rob1..3  in  IDX_W each  ROB index completing on port k
- ret_ready  in  1  retire stage accepts offered entries this cycle
- ret_valid1  out  1  head entry is complete and offered
- ret_valid2  out  1  head+1 entry is complete and offered
- ret_idx1  out  IDX_W  head index
- ret_idx2  out  IDX_W  head+1 mod DEPTH
- rob_count  out  IDX_W+1  occupied entries, 0..16
- rob_full  out  1  rob_count == 16
- rob_empty  out  1  rob_count == 0

Behaviour:
- State: head, tail (IDX_W bits), count (IDX_W+1 bits), valid[DEPTH], done[DEPTH].
- Reset (async, active-low): head=tail=0, count=0, valid=0, done=0. Every output then reads 0, except rob_empty=1 and rob_num2=1.
- Flush (synchronous):
  - Same effect as reset at the next edge; highest priority.
  - While flush=1: grants=0, ret_valid=0, disp_stall=0.
  - Completions and dispatches in that cycle are discarded.
- Dispatch (combinational grant, state updates at the edge):
  - ndisp = disp_req1 + disp_req2; free = 16 - count, using registered count only. A same-cycle retire gives no credit.
  - Grant is all-or-nothing: if free >= ndisp, grant every requested slot; otherwise grant none and disp_stall=1.
  - disp_req2 without disp_req1 is illegal: grant none, disp_stall=1, simulation assertion fires.
  - On a granted slot at the edge: valid[idx]=1, done[idx]=0, tail advances by the number granted, wrapping mod 16.
- Completion:
  - At the edge, done[cmpl_robk]=1 for each valid port k whose entry is valid. Completions to invalid entries are ignored.
  - Duplicate indices across ports are harmless.
  - A done bit is visible to retire one cycle after the completion is presented (1-cycle latency).
- Retire offer (combinational from registered state):
  - ret_valid1 = valid[head] & done[head].
  - ret_valid2 = ret_valid1 & valid[head+1] & done[head+1]. Slot 2 is never offered unless slot 1 is.
- Retire accept:
  - If ret_ready, at the edge clear valid/done for each offered entry and advance head by nret (0..2), wrapping mod 16.
  - If ret_ready=0, the offer holds and state is unchanged.
- Count: count_next = count + ngrant - nret. Simultaneous dispatch and retire are both applied. count never exceeds 16 and never goes below 0; each bound is a simulation assertion.
- Wrap-around: all index arithmetic is mod 16. rob_num2 and ret_idx2 wrap 15 -> 0.

Decomposition:
- Add to typedefs: ROB_DEPTH=16, ROB_IDX_W=4, typedef robIdx_t (logic[3:0]).
- Add struct robAllocStruct {grant1, grant2, robNum1, robNum2, stall} so the allocation result feeds robDispatchStruct.robNum1/2 directly.
- Add struct retireOfferStruct {valid1, valid2, idx1, idx2}.
- One natural sub-module, rob_done_tracker: holds the valid/done arrays, applies set and clear operations, and exposes the head/head+1 done bits. Pointers and count stay in the top.

Test Plan:
- Reset/empty: hold reset=0 mid-run with count=5, then release -> rob_count=0, rob_empty=1, ret_valid1=0. First dual request gets rob_num1=0, rob_num2=1.
- Fill/stall: 8 cycles of dual requests with no retire -> count=16, rob_full=1. Next disp_req1 alone -> grant1=0, disp_stall=1.
- Partial-space all-or-nothing: count=15 with dual request -> no grants, stall=1. Single request -> grant1=1 with rob_num1=tail, count becomes 16.
- Out-of-order completion: dispatch entries 0..3; complete 3, then 2, then 1 -> ret_valid1 stays 0. Complete 0 -> next cycle ret_valid1=1, ret_valid2=1 (idx 0,1). With ret_ready, the following cycle offers idx 2,3.
- Wrap plus simultaneous ops: head=14, tail=14. Dual dispatch gives rob_num 14,15; next dual dispatch gives 0,1. Retire 14,15 in the same cycle as dispatch of 2,3 -> head=0, tail=4, count=4.
- Flush: count=9 with pending completions and dispatch request, flush=1 -> grants=0. Next cycle count=0, head=tail=0, no ret_valid.
